// File: rtl/dcache_pkg.sv
// Shared data-cache definitions: geometry, memory request sizes, writeback
// request layout and the writeback serializer state encoding.
package dcache_pkg;

    // Cache and memory geometry used by the data-cache slice.
    localparam int unsigned DCACHE_LINE_WIDTH   = 128;
    localparam int unsigned XLEN                = 32;
    localparam int unsigned PLEN                = 34;
    localparam int unsigned DCACHE_OFFSET_WIDTH = 4;

    localparam int unsigned NUMBER_OF_WORDS_IN_CACHE_BLOCK = DCACHE_LINE_WIDTH / XLEN;

    // Encoded size field of a memory request.
    localparam logic [2:0] MEMORY_REQUEST_SIZE_ONE_BYTE   = 3'b000;
    localparam logic [2:0] MEMORY_REQUEST_SIZE_TWO_BYTES  = 3'b001;
    localparam logic [2:0] MEMORY_REQUEST_SIZE_FOUR_BYTES = 3'b010;
    localparam logic [2:0] MEMORY_REQUEST_SIZE_EIGHT_BYTES = 3'b011;
    localparam logic [2:0] MEMORY_REQUEST_SIZE_CACHEBLOCK = 3'b111;

    // One evicted line handed from the controller to the writeback path.
    typedef struct packed {
        logic                         flag;
        logic [DCACHE_LINE_WIDTH-1:0] data;
        logic [PLEN-1:0]              address;
    } writeback_t;

    typedef enum logic [1:0] {
        WB_IDLE      = 2'd0,
        WB_SEND      = 2'd1,
        WB_WAIT_DONE = 2'd2,
        WB_FINISH    = 2'd3
    } wb_serializer_state_t;

    // Align a CPU byte address to the natural boundary of the request size.
    function automatic logic [PLEN-1:0] cpu_to_memory_address(
        input logic [PLEN-1:0] address,
        input logic [2:0]      size
    );
        logic [PLEN-1:0] mask;
        mask = '1;
        case (size)
            MEMORY_REQUEST_SIZE_TWO_BYTES:   mask = mask << 1;
            MEMORY_REQUEST_SIZE_FOUR_BYTES:  mask = mask << 2;
            MEMORY_REQUEST_SIZE_EIGHT_BYTES: mask = mask << 3;
            MEMORY_REQUEST_SIZE_CACHEBLOCK:  mask = mask << DCACHE_OFFSET_WIDTH;
            default:                         mask = '1;
        endcase
        return address & mask;
    endfunction

endpackage

// File: rtl/dcache_writeback_serializer.sv
// Buffers one evicted dirty line and drains it to memory as word stores,
// one outstanding at a time, while flagging lookups that hit the line.
//
// Handshakes: the controller's line is transferred on a cycle where both
// wb_valid_i and wb_ready_o are high; the controller holds wb_valid_i and
// wb_i stable until then. A store is transferred on a cycle where mem_req_o
// and mem_gnt_i are both high; mem_req_o, mem_addr_o and mem_wdata_o stay
// stable until that cycle. Its completion is the next mem_rtrn_vld_i seen
// while waiting; returns at any other time are ignored.
module dcache_writeback_serializer
    import dcache_pkg::*;
#(
    parameter int unsigned LINE_WIDTH   = dcache_pkg::DCACHE_LINE_WIDTH,
    parameter int unsigned WORD_WIDTH   = dcache_pkg::XLEN,
    parameter int unsigned ADDR_WIDTH   = dcache_pkg::PLEN,
    parameter int unsigned OFFSET_WIDTH = dcache_pkg::DCACHE_OFFSET_WIDTH
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    wb_valid_i,
    output logic                    wb_ready_o,
    input  writeback_t              wb_i,
    output logic                    wb_done_o,
    output logic                    busy_o,
    input  logic [ADDR_WIDTH-1:0]   lookup_addr_i,
    output logic                    lookup_hit_o,
    output logic                    mem_req_o,
    input  logic                    mem_gnt_i,
    output logic [ADDR_WIDTH-1:0]   mem_addr_o,
    output logic [WORD_WIDTH-1:0]   mem_wdata_o,
    output logic [2:0]              mem_size_o,
    output logic [WORD_WIDTH/8-1:0] mem_be_o,
    input  logic                    mem_rtrn_vld_i,
    output wb_serializer_state_t    state_o
);

    localparam int unsigned NUM_WORDS  = LINE_WIDTH / WORD_WIDTH;
    localparam int unsigned CNT_W      = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int unsigned BYTE_SHIFT = $clog2(WORD_WIDTH / 8);

    wb_serializer_state_t  state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [LINE_WIDTH-1:0] buffer_q;
    logic [ADDR_WIDTH-1:0] base_q;
    logic                  load;
    logic                  last_word;

    // The flag field and the lookup byte offset carry no meaning here.
    logic unused_bits;
    assign unused_bits = ^{wb_i.flag, lookup_addr_i[OFFSET_WIDTH-1:0]};

    assign last_word = (cnt_q == CNT_W'(NUM_WORDS - 1));

    // State, word counter and line buffer registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= WB_IDLE;
            cnt_q    <= '0;
            buffer_q <= '0;
            base_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (load) begin
                buffer_q <= LINE_WIDTH'(wb_i.data);
                base_q   <= ADDR_WIDTH'(cpu_to_memory_address(wb_i.address,
                                                             MEMORY_REQUEST_SIZE_CACHEBLOCK));
            end
        end
    end

    // Next-state, counter and control outputs for the drain sequence.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        load       = 1'b0;
        wb_ready_o = 1'b0;
        wb_done_o  = 1'b0;
        busy_o     = 1'b0;
        mem_req_o  = 1'b0;
        case (state_q)
            WB_IDLE: begin
                wb_ready_o = 1'b1;
                if (wb_valid_i) begin
                    load    = 1'b1;
                    cnt_d   = '0;
                    state_d = WB_SEND;
                end
            end
            WB_SEND: begin
                busy_o    = 1'b1;
                mem_req_o = 1'b1;
                if (mem_gnt_i) begin
                    state_d = WB_WAIT_DONE;
                end
            end
            WB_WAIT_DONE: begin
                busy_o = 1'b1;
                if (mem_rtrn_vld_i) begin
                    if (last_word) begin
                        state_d = WB_FINISH;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        state_d = WB_SEND;
                    end
                end
            end
            WB_FINISH: begin
                // Line is already coherent in memory, so a new line may enter now.
                wb_done_o  = 1'b1;
                wb_ready_o = 1'b1;
                if (wb_valid_i) begin
                    load    = 1'b1;
                    cnt_d   = '0;
                    state_d = WB_SEND;
                end else begin
                    state_d = WB_IDLE;
                end
            end
            default: begin
                state_d = WB_IDLE;
            end
        endcase
    end

    // Store fields follow the buffer and counter, so they hold while ungranted.
    assign mem_addr_o  = base_q + (ADDR_WIDTH'(cnt_q) << BYTE_SHIFT);
    assign mem_wdata_o = buffer_q[cnt_q*WORD_WIDTH +: WORD_WIDTH];
    assign mem_size_o  = MEMORY_REQUEST_SIZE_FOUR_BYTES;
    assign mem_be_o    = '1;

    assign lookup_hit_o = busy_o &&
        (lookup_addr_i[ADDR_WIDTH-1:OFFSET_WIDTH] == base_q[ADDR_WIDTH-1:OFFSET_WIDTH]);

    assign state_o = state_q;

endmodule

// File: tb/tb_dcache_writeback_serializer.sv
// Directed bench for the writeback serializer: drains, grant stall,
// hazard lookup, back-to-back lines and reset mid-drain.
module tb_dcache_writeback_serializer;
    import dcache_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst_i = 1'b1;
    logic                 wb_valid_i = 1'b0;
    logic                 wb_ready_o;
    writeback_t           wb_i = '0;
    logic                 wb_done_o;
    logic                 busy_o;
    logic [PLEN-1:0]      lookup_addr_i = '0;
    logic                 lookup_hit_o;
    logic                 mem_req_o;
    logic                 mem_gnt_i = 1'b0;
    logic [PLEN-1:0]      mem_addr_o;
    logic [XLEN-1:0]      mem_wdata_o;
    logic [2:0]           mem_size_o;
    logic [XLEN/8-1:0]    mem_be_o;
    logic                 mem_rtrn_vld_i = 1'b0;
    wb_serializer_state_t state_o;

    int checks = 0;
    int errors = 0;

    dcache_writeback_serializer dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .wb_valid_i     (wb_valid_i),
        .wb_ready_o     (wb_ready_o),
        .wb_i           (wb_i),
        .wb_done_o      (wb_done_o),
        .busy_o         (busy_o),
        .lookup_addr_i  (lookup_addr_i),
        .lookup_hit_o   (lookup_hit_o),
        .mem_req_o      (mem_req_o),
        .mem_gnt_i      (mem_gnt_i),
        .mem_addr_o     (mem_addr_o),
        .mem_wdata_o    (mem_wdata_o),
        .mem_size_o     (mem_size_o),
        .mem_be_o       (mem_be_o),
        .mem_rtrn_vld_i (mem_rtrn_vld_i),
        .state_o        (state_o)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just past the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer a line in the current (ready) cycle; returns in the first SEND cycle.
    task automatic start_line(input logic [127:0] data, input logic [PLEN-1:0] addr);
        check("start_ready", wb_ready_o, 1'b1);
        wb_i.flag    = 1'b1;
        wb_i.data    = data;
        wb_i.address = addr;
        wb_valid_i   = 1'b1;
        tick();
        wb_valid_i = 1'b0;
    endtask

    // Drain four words from the first SEND cycle; ends in the FINISH cycle.
    // stall_word gets stall_n ungranted cycles, with a spurious return in each.
    task automatic drain(input logic [127:0] data, input logic [PLEN-1:0] base,
                         input int stall_word, input int stall_n);
        logic [127:0] line;
        line = data;
        lookup_addr_i = base | 34'h8;
        for (int w = 0; w < 4; w++) begin
            int n;
            n = (w == stall_word) ? stall_n : 0;
            for (int s = 0; s <= n; s++) begin
                #0;
                check($sformatf("req_w%0d_s%0d", w, s), mem_req_o, 1'b1);
                check($sformatf("addr_w%0d_s%0d", w, s), mem_addr_o, base + 34'(w * 4));
                check($sformatf("data_w%0d_s%0d", w, s), mem_wdata_o, line[w*32 +: 32]);
                check($sformatf("state_send_w%0d", w), state_o, WB_SEND);
                check($sformatf("busy_send_w%0d", w), busy_o, 1'b1);
                check($sformatf("hit_send_w%0d", w), lookup_hit_o, 1'b1);
                check($sformatf("done_send_w%0d", w), wb_done_o, 1'b0);
                mem_gnt_i      = (s == n);
                mem_rtrn_vld_i = (s < n);
                tick();
            end
            mem_gnt_i      = 1'b0;
            mem_rtrn_vld_i = 1'b0;
            check($sformatf("req_wait_w%0d", w), mem_req_o, 1'b0);
            check($sformatf("state_wait_w%0d", w), state_o, WB_WAIT_DONE);
            check($sformatf("done_wait_w%0d", w), wb_done_o, 1'b0);
            if (w == 1) begin
                lookup_addr_i = base + 34'h10;
                #1;
                check("hit_next_line", lookup_hit_o, 1'b0);
                lookup_addr_i = base | 34'h8;
            end
            mem_rtrn_vld_i = 1'b1;
            tick();
            mem_rtrn_vld_i = 1'b0;
        end
        check("finish_done", wb_done_o, 1'b1);
        check("finish_ready", wb_ready_o, 1'b1);
        check("finish_busy", busy_o, 1'b0);
        check("finish_req", mem_req_o, 1'b0);
        check("finish_hit", lookup_hit_o, 1'b0);
    endtask

    initial begin
        logic [127:0] line_a;
        logic [127:0] line_b;
        logic [127:0] line_c;
        line_a = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
        line_b = 128'h44444444_33333333_22222222_11111111;
        line_c = 128'h0BADF00D_CAFEBABE_12345678_DEADBEEF;

        // reset state
        rst_i = 1'b1;
        tick();
        tick();
        rst_i = 1'b0;
        check("rst_state", state_o, WB_IDLE);
        check("rst_ready", wb_ready_o, 1'b1);
        check("rst_busy", busy_o, 1'b0);
        check("rst_req", mem_req_o, 1'b0);
        check("rst_done", wb_done_o, 1'b0);
        check("rst_hit", lookup_hit_o, 1'b0);
        check("rst_addr", mem_addr_o, 34'h0);
        check("rst_wdata", mem_wdata_o, 32'h0);
        check("size", mem_size_o, 3'b010);
        check("be", mem_be_o, 4'hF);

        // basic drain, best case: done in cycle 9
        start_line(line_a, 34'h0_8000_1234);
        drain(line_a, 34'h0_8000_1230, -1, 0);
        tick();
        check("idle_after_a", state_o, WB_IDLE);
        check("idle_done_low", wb_done_o, 1'b0);
        lookup_addr_i = 34'h0_8000_1238;
        #1;
        check("idle_hit", lookup_hit_o, 1'b0);

        // stray return while idle is ignored
        mem_rtrn_vld_i = 1'b1;
        tick();
        mem_rtrn_vld_i = 1'b0;
        check("stray_rtrn_state", state_o, WB_IDLE);
        check("stray_rtrn_req", mem_req_o, 1'b0);

        // grant stall of 5 cycles on word 2
        start_line(line_b, 34'h0_0000_0A5C);
        drain(line_b, 34'h0_0000_0A50, 2, 5);
        tick();
        check("idle_after_b", state_o, WB_IDLE);

        // back-to-back: second line offered in the FINISH cycle
        start_line(line_a, 34'h0_8000_1234);
        drain(line_a, 34'h0_8000_1230, -1, 0);
        start_line(line_c, 34'h1_2345_6788);
        check("b2b_state", state_o, WB_SEND);
        drain(line_c, 34'h1_2345_6780, -1, 0);
        tick();
        check("idle_after_c", state_o, WB_IDLE);

        // reset after the word 1 grant
        start_line(line_b, 34'h0_0000_0A5C);
        mem_gnt_i = 1'b1;
        tick();
        mem_gnt_i      = 1'b0;
        mem_rtrn_vld_i = 1'b1;
        tick();
        mem_rtrn_vld_i = 1'b0;
        check("rstmid_w1_addr", mem_addr_o, 34'h0_0000_0A54);
        mem_gnt_i = 1'b1;
        tick();
        mem_gnt_i = 1'b0;
        check("rstmid_wait", state_o, WB_WAIT_DONE);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        check("rstmid_req", mem_req_o, 1'b0);
        check("rstmid_ready", wb_ready_o, 1'b1);
        check("rstmid_done", wb_done_o, 1'b0);
        check("rstmid_busy", busy_o, 1'b0);
        check("rstmid_wdata", mem_wdata_o, 32'h0);
        mem_rtrn_vld_i = 1'b1;
        tick();
        mem_rtrn_vld_i = 1'b0;
        check("rstmid_stray_state", state_o, WB_IDLE);
        check("rstmid_stray_done", wb_done_o, 1'b0);
        check("rstmid_stray_req", mem_req_o, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
